// File: rtl/i2s_rx_if.sv
// i2s_rx_if: serial I2S pins plus the deserialised stereo sample outputs of the receiver.
interface i2s_rx_if #(
    parameter int AUDIO_DW = 16
);
    logic                i2s_bck;
    logic                i2s_lrck;
    logic                i2s_data;
    logic [AUDIO_DW-1:0] left;
    logic [AUDIO_DW-1:0] right;
    logic                sample_valid;
    logic                frame_err;
    modport master (
        output i2s_bck, i2s_lrck, i2s_data,
        input  left, right, sample_valid, frame_err
    );
    modport slave (
        input  i2s_bck, i2s_lrck, i2s_data,
        output left, right, sample_valid, frame_err
    );
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx: oversampling Philips I2S receiver presenting one stereo pair per frame.
// The bit on a word-select change is the LSB of the slot that is ending (1-bit delay).
module i2s_rx #(
    parameter int AUDIO_DW = 16,
    parameter int CNT_W    = 6
) (
    input logic     clk_sys,
    input logic     reset_n,
    i2s_rx_if.slave bus
);
    typedef enum logic {SYNC, RUN} state_t;
    localparam logic [CNT_W:0] DW = (CNT_W+1)'(AUDIO_DW);
    state_t              r_state, w_state_next;
    logic [1:0]          r_bck_s, r_lr_s, r_d_s;
    logic                r_bck_q, r_lr_prev, r_left_ok, r_valid, r_err;
    logic [CNT_W-1:0]    r_bitcnt;
    logic [AUDIO_DW-1:0] r_shreg, r_left_hold, r_left, r_right;
    logic                w_rise, w_lr, w_d, w_bnd, w_shift, w_short;
    logic                w_err, w_load_l, w_pair, w_drop_l;
    logic [CNT_W:0]      w_len;
    logic [AUDIO_DW-1:0] w_word;
    assign w_rise  = r_bck_s[1] & ~r_bck_q;
    assign w_lr    = r_lr_s[1];
    assign w_d     = r_d_s[1];
    assign w_bnd   = w_rise && (w_lr != r_lr_prev);
    assign w_shift = {1'b0, r_bitcnt} < DW;
    assign w_word  = w_shift ? {r_shreg[AUDIO_DW-2:0], w_d} : r_shreg;
    // slot length counts the boundary bit, which belongs to the ending slot
    assign w_len   = {1'b0, r_bitcnt} + (CNT_W+1)'(1);
    assign w_short = w_len < DW;
    always_ff @(posedge clk_sys) begin
        if (!reset_n) r_state <= SYNC;
        else          r_state <= w_state_next;
    end
    always_comb begin
        w_state_next = r_state;
        w_err        = 1'b0;
        w_load_l     = 1'b0;
        w_pair       = 1'b0;
        w_drop_l     = 1'b0;
        if (r_state == SYNC) begin
            if (w_bnd) w_state_next = RUN;
        end else if (w_bnd) begin
            w_err    = w_short;
            w_load_l = !w_short && !r_lr_prev;
            w_pair   = !w_short && r_lr_prev && r_left_ok;
            w_drop_l = w_short || r_lr_prev;
        end
    end
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_bck_s     <= '0;
            r_lr_s      <= '0;
            r_d_s       <= '0;
            r_bck_q     <= 1'b0;
            r_lr_prev   <= 1'b0;
            r_left_ok   <= 1'b0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_bitcnt    <= '0;
            r_shreg     <= '0;
            r_left_hold <= '0;
            r_left      <= '0;
            r_right     <= '0;
        end else begin
            r_bck_s <= {r_bck_s[0], bus.i2s_bck};
            r_lr_s  <= {r_lr_s[0], bus.i2s_lrck};
            r_d_s   <= {r_d_s[0], bus.i2s_data};
            r_bck_q <= r_bck_s[1];
            r_valid <= w_pair;
            r_err   <= w_err;
            if (w_rise) begin
                r_lr_prev <= w_lr;
                if (w_bnd) begin
                    r_bitcnt <= '0;
                    r_shreg  <= '0;
                end else if (r_state == RUN) begin
                    if (w_shift) r_shreg <= w_word;
                    if (r_bitcnt != '1) r_bitcnt <= r_bitcnt + CNT_W'(1);
                end
            end
            if (w_load_l) begin
                r_left_hold <= w_word;
                r_left_ok   <= 1'b1;
            end else if (w_drop_l) begin
                r_left_ok   <= 1'b0;
            end
            if (w_pair) begin
                r_left  <= r_left_hold;
                r_right <= w_word;
            end
        end
    end
    assign bus.left         = r_left;
    assign bus.right        = r_right;
    assign bus.sample_valid = r_valid;
    assign bus.frame_err    = r_err;
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: drives Philips-format I2S at clk_sys = 8x bck; a monitor pops expected
// stereo pairs from a scoreboard queue on every sample_valid and counts frame_err pulses.
module tb_i2s_rx;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        pend    = 1'b0;
    int          checks  = 0;
    int          errors  = 0;
    int          n_ferr  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    i2s_rx_if #(.AUDIO_DW(16)) bus ();
    i2s_rx #(.AUDIO_DW(16), .CNT_W(6)) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (bus.sample_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid got left=%h right=%h want no strobe", bus.left, bus.right);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.left, bus.right} !== mon_e) begin
                    errors++;
                    $display("FAIL sample_pair got %h_%h want %h_%h", bus.left, bus.right, mon_e[31:16], mon_e[15:0]);
                end
            end
            if (bus.frame_err === 1'b1) begin
                errors++;
                $display("FAIL valid_and_err got both high want exclusive");
            end
        end
        if (bus.frame_err === 1'b1) n_ferr++;
    end

    // one bck period: lrck/data change while bck is low, 4 clks low then 4 clks high
    task automatic bit_period(input logic lr, input logic d);
        bus.i2s_lrck = lr;
        bus.i2s_data = d;
        repeat (4) @(negedge clk_sys);
        bus.i2s_bck = 1'b1;
        repeat (4) @(negedge clk_sys);
        bus.i2s_bck = 1'b0;
    endtask

    // word is left-aligned in 32 bits; data lags lrck by one bit period
    task automatic send_bits(input logic lr, input logic [31:0] w, input int from, input int to);
        for (int i = from; i < to; i++) begin
            bit_period(lr, pend);
            pend = w[31-i];
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int len);
        send_bits(1'b0, l, 0, len);
        send_bits(1'b1, r, 0, len);
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        bus.i2s_bck  = 1'b0;
        bus.i2s_lrck = 1'b0;
        bus.i2s_data = 1'b0;
        pend         = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        n_ferr = 0;
    endtask

    // one left-slot bit closes the last right slot, then let the pipeline drain
    task automatic finish_test(input string name, input int exp_ferr);
        send_bits(1'b0, 32'h0, 0, 1);
        repeat (40) @(negedge clk_sys);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got %0d outstanding want 0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (n_ferr !== exp_ferr) begin
            errors++;
            $display("FAIL %s_frame_err got %0d pulses want %0d", name, n_ferr, exp_ferr);
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.i2s_bck  = 1'b0;
        bus.i2s_lrck = 1'b0;
        bus.i2s_data = 1'b0;
        repeat (3) @(negedge clk_sys);
        checks++;
        if (bus.left !== 16'h0) begin errors++; $display("FAIL reset_left got %h want 0000", bus.left); end
        checks++;
        if (bus.right !== 16'h0) begin errors++; $display("FAIL reset_right got %h want 0000", bus.right); end
        checks++;
        if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.sample_valid); end
        checks++;
        if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.frame_err); end
    endtask

    task automatic test_slot32();
        do_reset();
        send_frame(32'h1234_0000, 32'hABCD_0000, 32);
        exp_q.push_back({16'h1234, 16'hABCD});
        exp_q.push_back({16'h1234, 16'hABCD});
        send_frame(32'h1234_0000, 32'hABCD_0000, 32);
        send_frame(32'h1234_0000, 32'hABCD_0000, 32);
        finish_test("slot32", 0);
    endtask

    task automatic test_slot16();
        do_reset();
        send_frame(32'h8001_0000, 32'h7FFE_0000, 16);
        repeat (3) exp_q.push_back({16'h8001, 16'h7FFE});
        repeat (3) send_frame(32'h8001_0000, 32'h7FFE_0000, 16);
        finish_test("slot16", 0);
    endtask

    task automatic test_trunc24();
        do_reset();
        send_frame(32'h1234_5600, 32'hFEDC_BA00, 32);
        exp_q.push_back({16'h1234, 16'hFEDC});
        send_frame(32'h1234_5600, 32'hFEDC_BA00, 32);
        finish_test("trunc24", 0);
    endtask

    // continues from the previous stream without reset: every slot is short
    task automatic test_short8();
        n_ferr = 0;
        repeat (3) send_frame(32'hA500_0000, 32'h5A00_0000, 8);
        finish_test("short8", 6);
        checks++;
        if (bus.left !== 16'h1234) begin errors++; $display("FAIL short8_hold_left got %h want 1234", bus.left); end
        checks++;
        if (bus.right !== 16'hFEDC) begin errors++; $display("FAIL short8_hold_right got %h want fedc", bus.right); end
    endtask

    task automatic test_short15();
        do_reset();
        repeat (3) send_frame(32'hFFFE_0000, 32'hFFFE_0000, 15);
        finish_test("short15", 5);
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_frame(32'h1111_0000, 32'h2222_0000, 32);
        exp_q.push_back({16'h3333, 16'h4444});
        send_frame(32'h3333_0000, 32'h4444_0000, 32);
        send_bits(1'b0, 32'h5555_0000, 0, 32);
        send_bits(1'b1, 32'h6666_0000, 0, 16);
        repeat (20) @(negedge clk_sys);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_pre got %0d outstanding want 0", exp_q.size());
            exp_q.delete();
        end
        reset_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        checks++;
        if (bus.left !== 16'h0) begin errors++; $display("FAIL mid_reset_left got %h want 0000", bus.left); end
        checks++;
        if (bus.right !== 16'h0) begin errors++; $display("FAIL mid_reset_right got %h want 0000", bus.right); end
        n_ferr = 0;
        exp_q.push_back({16'h7777, 16'h8888});
        exp_q.push_back({16'h9999, 16'hAAAA});
        send_bits(1'b1, 32'h6666_0000, 16, 32);
        send_frame(32'h7777_0000, 32'h8888_0000, 32);
        send_frame(32'h9999_0000, 32'hAAAA_0000, 32);
        finish_test("mid_reset", 0);
    endtask

    task automatic test_right_first();
        do_reset();
        send_bits(1'b1, 32'hDEAD_0000, 0, 32);
        exp_q.push_back({16'hC0DE, 16'hBEEF});
        send_frame(32'hC0DE_0000, 32'hBEEF_0000, 32);
        finish_test("right_first", 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] l[5];
        logic [31:0] r[5];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            l[i] = $urandom;
            r[i] = $urandom;
            if (i > 0) exp_q.push_back({l[i][31:16], r[i][31:16]});
        end
        for (int i = 0; i < 5; i++) send_frame(l[i], r[i], 32);
        finish_test("back_to_back", 0);
    endtask

    initial begin
        test_reset();
        test_slot32();
        test_slot16();
        test_trunc24();
        test_short8();
        test_short15();
        test_mid_reset();
        test_right_first();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
